// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one combinational adder among NREQ requesters,
// with a single registered result slot. Define ADDER_SHARE_ARB_OVF_EN to add rsp_ovf.
module adder_share_arbiter #(
  parameter int WIDTH = 20,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_o,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data
`ifdef ADDER_SHARE_ARB_OVF_EN
  ,
  output logic                   rsp_ovf
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic            can_issue;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  ptr_next;
  int unsigned     scan_idx;

  // Search ptr, ptr+1, ... wrapping; first valid requester wins.
  always_comb begin
    can_issue = (state == EMPTY) || rsp_ready;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    if (!rst && can_issue) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        scan_idx = 32'(ptr) + k;
        if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
        if (!gnt_valid && req_valid[scan_idx[IDW-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = scan_idx[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_valid) req_ready[gnt_idx] = 1'b1;
  end

  // Idle cycles still drive a deterministic operand pair (requester ptr).
  assign sel   = gnt_valid ? gnt_idx : ptr;
  assign add_a = req_a[sel*WIDTH +: WIDTH];
  assign add_b = req_b[sel*WIDTH +: WIDTH];

  assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign rsp_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
`ifdef ADDER_SHARE_ARB_OVF_EN
      rsp_ovf  <= 1'b0;
`endif
    end else if (gnt_valid) begin
      state    <= FULL;
      ptr      <= ptr_next;
      rsp_id   <= gnt_idx;
      rsp_data <= add_o;
`ifdef ADDER_SHARE_ARB_OVF_EN
      rsp_ovf  <= (add_o < add_a);
`endif
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops and compares on each response handshake.
module tb_adder_share_arbiter;
  localparam int W    = 20;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*W-1:0]     req_a;
  logic [NREQ*W-1:0]     req_b;
  logic [W-1:0]          add_a;
  logic [W-1:0]          add_b;
  logic [W-1:0]          add_o;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [W-1:0]          rsp_data;
`ifdef ADDER_SHARE_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic           ovf;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // The shared adder itself.
  assign add_o = add_a + add_b;

  adder_share_arbiter #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ADDER_SHARE_ARB_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [W-1:0] data, input logic ovf);
    exp_t e;
    e.id   = IDW'(id);
    e.data = data;
    e.ovf  = ovf;
    sbq.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", {30'd0, rsp_id}, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
`ifdef ADDER_SHARE_ARB_OVF_EN
          chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
`endif
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i), W'('h10));

    // Reset with all requests valid.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    end
    next_drive();
    rst = 1'b0;

    // Round-robin: grants 0,1,2,3,0,1,2,3 back to back.
    for (int k = 0; k < 8; k++) begin
      push(k % 4, W'('h10 + (k % 4)), 1'b0);
      @(negedge clk);
      chk("rr_req_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
      next_drive();
    end
    req_valid = '0;

    // Single request from requester 2.
    req_valid = 4'b0100;
    set_op(2, 20'h00005, 20'h00007);
    push(2, 20'h0000C, 1'b0);
    @(negedge clk);
    chk("single_req_ready", 32'(req_ready), 32'h4);
    next_drive();
    req_valid = '0;
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    next_drive();

    // Wrap-around and carry-out, issued back to back from requester 1.
    req_valid = 4'b0010;
    set_op(1, 20'hFFFFF, 20'h00002);
    push(1, 20'h00001, 1'b1);
    @(negedge clk);
    chk("wrap_req_ready", 32'(req_ready), 32'h2);
    next_drive();
    set_op(1, 20'h00001, 20'h00002);
    push(1, 20'h00003, 1'b0);
    @(negedge clk);
    chk("nowrap_req_ready", 32'(req_ready), 32'h2);
    next_drive();
    req_valid = '0;
    @(negedge clk);
    next_drive();

    // Backpressure: result held while requester 3 waits.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 20'h00100, 20'h00023);
    push(0, 20'h00123, 1'b0);
    @(negedge clk);
    chk("bp_first_req_ready", 32'(req_ready), 32'h1);
    next_drive();
    req_valid = 4'b1000;
    set_op(3, 20'h00300, 20'h00045);
    push(3, 20'h00345, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_id", 32'(rsp_id), 32'h0);
      chk("bp_rsp_data", 32'(rsp_data), 32'h00123);
      next_drive();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req_ready", 32'(req_ready), 32'h8);
    next_drive();
    req_valid = '0;
    @(negedge clk);
    chk("bp_next_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_next_rsp_id", 32'(rsp_id), 32'h3);
    next_drive();

    // Reset while a result is pending: it must vanish, ptr back to 0.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    set_op(2, 20'h00001, 20'h00001);
    @(negedge clk);
    chk("mid_req_ready", 32'(req_ready), 32'h4);
    next_drive();
    req_valid = '0;
    @(negedge clk);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h1);
    next_drive();
    rst       = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i), W'('h10));
    @(negedge clk);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    next_drive();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    push(0, 20'h00010, 1'b0);
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_rst_req_ready", 32'(req_ready), 32'h1);
    next_drive();
    req_valid = '0;

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    chk("drain_empty", 32'(sbq.size()), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one combinational WIDTH-bit adder (a + b -> o, wrap-around, no carry out) between NREQ requesters.
- Arbitration is round-robin.
- Each requester has a valid/ready request channel; there is one shared valid/ready response channel.
- Sits in the ALU arithmetic layer, between the issue logic and the shared adder instance.

Parameters:
- WIDTH, 20, operand/result width; matches the adder.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand b; same packing as req_a
- add_a  out  WIDTH  to adder input a
- add_b  out  WIDTH  to adder input b
- add_o  in  WIDTH  from adder output o (combinational)
- rsp_valid  out  1  result register holds a valid result
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_data  out  WIDTH  registered sum

Behaviour:
- Reset (rst high at a clk edge), outputs:
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - Round-robin pointer=0.
  - req_ready=0 while rst is high.
- Reset mid-operation: an in-flight result is discarded; no response is produced for it.
- State machine, two states:
  - EMPTY: result register invalid.
  - FULL: result register valid.
- can_issue = EMPTY, or (FULL and rsp_ready).
- Grant (combinational):
  - When can_issue, grant the first i with req_valid[i]=1, searching ptr, ptr+1, …, NREQ-1, 0, …, wrapping modulo NREQ.
  - req_ready[g]=1 for the granted index only. All other bits are 0.
  - When no request is valid, or can_issue=0, req_ready is all zero.
- Adder drive:
  - add_a/add_b = operands of the granted requester.
  - When there is no grant, add_a/add_b = operands of requester ptr. This is don't-care for correctness but must be deterministic.
- On a clk edge with a grant g:
  - rsp_data <= add_o.
  - rsp_id <= g.
  - rsp_valid <= 1 (state FULL).
  - ptr <= (g+1) mod NREQ.
- On a clk edge with FULL, rsp_ready=1 and no grant: rsp_valid <= 0 (state EMPTY). ptr unchanged.
- FULL and rsp_ready=0:
  - All outputs hold.
  - req_ready=0 (backpressure).
- Simultaneous drain and issue (FULL, rsp_ready=1, valid request):
  - Old result is consumed and the new one is loaded in the same edge.
  - Sustained throughput is 1 result per cycle.
- Latency: request accepted at edge N -> rsp_valid=1 with its result after edge N, i.e. in cycle N+1.
- Arithmetic: rsp_data = (a + b) mod 2**WIDTH, exactly as returned by add_o.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,…,NREQ-1,0,… Each requester waits at most NREQ-1 grants.
- Requesters must hold req_valid and operands stable until req_ready is seen. The arbiter does not latch unaccepted requests.
- rsp_valid, once high, stays high with stable rsp_id/rsp_data until a rsp_ready cycle.

Optional Feature:
- Macro: ADDER_SHARE_ARB_OVF_EN.
- Defined:
  - Adds output port rsp_ovf (1 bit), reset value 0.
  - Registered alongside rsp_data as (add_o < add_a), the unsigned carry-out of the granted addition.
  - Holds and clears with the same rules as rsp_data.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0 during reset. The first grant after release goes to requester 0.
- Single request: req 2 with a=0x00005, b=0x00007, rsp_ready=1 -> req_ready=4'b0100 for one cycle. Next cycle: rsp_valid=1, rsp_id=2, rsp_data=0x0000C.
- Wrap: req 1 with a=0xFFFFF, b=0x00002 -> rsp_data=0x00001. With ADDER_SHARE_ARB_OVF_EN, rsp_ovf=1; with a=0x00001, b=0x00002, rsp_ovf=0.
- Round-robin: all 4 valid, each with a=i, b=0x10, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3; rsp_data = 0x10+id; rsp_valid continuously 1.
- Backpressure: result pending with rsp_ready=0 for 3 cycles while req 3 is valid -> req_ready=0, and rsp_id/rsp_data stay stable. On the cycle rsp_ready=1, req 3 is granted in that same cycle; its result appears the next cycle.
- Reset mid-operation: rsp_valid=1 with rsp_ready=0, then pulse rst -> rsp_valid=0 next cycle, ptr=0, pending result lost.
